// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the two-master external bus arbiter.
//   state_t    : FSM encoding, identical to the owner code on the owner pins
//   OWNER_*    : owner pin codes (none / CPU / DMA / turnaround)
//   ctl_t      : {memNotRead, memNotWrite, csh_n, csl_n, select_dev}
//   CTL_IDLE   : all strobes deasserted, memory space selected
//   CTL_*      : bit positions of the individual fields inside ctl_t
package bus_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CPU  = 2'b01,
    ST_DMA  = 2'b10,
    ST_TURN = 2'b11
  } state_t;

  localparam logic [1:0] OWNER_NONE = 2'b00;
  localparam logic [1:0] OWNER_CPU  = 2'b01;
  localparam logic [1:0] OWNER_DMA  = 2'b10;
  localparam logic [1:0] OWNER_TURN = 2'b11;

  typedef logic [4:0] ctl_t;

  localparam ctl_t CTL_IDLE = 5'b11110;

  localparam int CTL_NRD = 4;  // memNotRead
  localparam int CTL_NWR = 3;  // memNotWrite
  localparam int CTL_CSH = 2;  // csh_n
  localparam int CTL_CSL = 1;  // csl_n
  localparam int CTL_SEL = 0;  // select_dev

endpackage

// File: rtl/bus_arbiter_if.sv
// Request/grant and bus-access bundle between one bus master and the arbiter.
//   req      : master requests the bus, held high for the whole tenure
//   gnt      : master owns the bus
//   address  : 15-bit address presented by the master
//   data_out : write data presented by the master
//   data_in  : external bus data returned to the master
//   ctl      : {memNotRead, memNotWrite, csh_n, csl_n, select_dev}
// Modports: master (the CPU or DMA side), slave (the arbiter side).
interface bus_arbiter_if;
  import bus_arbiter_pkg::*;

  logic        req;
  logic        gnt;
  logic [14:0] address;
  logic [15:0] data_out;
  logic [15:0] data_in;
  ctl_t        ctl;

  modport master (output req, address, data_out, ctl, input gnt, data_in);
  modport slave  (input req, address, data_out, ctl, output gnt, data_in);

endinterface

// File: rtl/bus_mux.sv
// Owner-select of the external bus. Purely combinational: address and
// control follow the owning master, and the data pins are driven only while
// the owner performs a write. With no owner (idle or turnaround) the bus is
// parked at address 0 with all strobes deasserted and data released.
//   owner        : registered owner code from the arbiter FSM
//   cpu_* / dma_*: address, write data and control from each master
//   address, ctl : external address and control strobes
//   data         : external tri-state data pins
module bus_mux
  import bus_arbiter_pkg::*;
(
  input  logic [1:0]  owner,
  input  logic [14:0] cpu_address,
  input  logic [15:0] cpu_data_out,
  input  ctl_t        cpu_ctl,
  input  logic [14:0] dma_address,
  input  logic [15:0] dma_data_out,
  input  ctl_t        dma_ctl,
  output logic [14:0] address,
  output ctl_t        ctl,
  inout  wire  [15:0] data
);

  logic        drive_en;
  logic [15:0] drive_val;

  always_comb begin
    address   = '0;
    ctl       = CTL_IDLE;
    drive_en  = 1'b0;
    drive_val = '0;
    case (owner)
      OWNER_CPU: begin
        address   = cpu_address;
        ctl       = cpu_ctl;
        drive_en  = ~cpu_ctl[CTL_NWR];
        drive_val = cpu_data_out;
      end
      OWNER_DMA: begin
        address   = dma_address;
        ctl       = dma_ctl;
        drive_en  = ~dma_ctl[CTL_NWR];
        drive_val = dma_data_out;
      end
      OWNER_NONE, OWNER_TURN: begin
      end
      default: begin
      end
    endcase
  end

  assign data = drive_en ? drive_val : {16{1'bz}};

endmodule

// File: rtl/bus_arbiter.sv
// Two-master arbiter for the external memory/device bus.
// CPU (master 0) has fixed priority and unlimited tenure; the DMA engine
// (master 1) is preempted after MAX_DMA_BURST owned cycles with the CPU
// waiting, but only on a cycle where it has no access in flight. Every
// release inserts TURNAROUND_CYCLES idle cycles before the next owner.
//   clock, notReset : clock and asynchronous active-low reset
//   cpu, dma        : request/grant/access bundles of the two masters
//   address, data   : external address and tri-state data pins
//   memNotRead, memNotWrite, csh_n, csl_n, select_dev : external strobes
//   owner           : 00 none, 01 CPU, 10 DMA, 11 turnaround
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int MAX_DMA_BURST     = 8,
  parameter int TURNAROUND_CYCLES = 1
) (
  input  logic         clock,
  input  logic         notReset,
  bus_arbiter_if.slave cpu,
  bus_arbiter_if.slave dma,
  output logic [14:0]  address,
  inout  wire  [15:0]  data,
  output logic         memNotRead,
  output logic         memNotWrite,
  output logic         csh_n,
  output logic         csl_n,
  output logic         select_dev,
  output logic [1:0]   owner
);

  localparam logic [7:0] BURST_MAX = 8'(MAX_DMA_BURST);
  localparam logic [1:0] TURN_LAST = 2'(TURNAROUND_CYCLES - 1);

  state_t     state_reg, state_next;
  logic [7:0] burst_cnt_reg, burst_cnt_next;
  logic [1:0] turn_cnt_reg, turn_cnt_next;
  logic       last_cpu_reg, last_cpu_next;   // 1: CPU released last
  logic       dma_fair_reg, dma_fair_next;   // DMA was waiting at CPU release

  state_t     arb_state;
  state_t     release_state;
  logic [7:0] burst_sat;
  logic       released;
  ctl_t       bus_ctl;

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      state_reg     <= ST_IDLE;
      burst_cnt_reg <= '0;
      turn_cnt_reg  <= '0;
      last_cpu_reg  <= 1'b0;
      dma_fair_reg  <= 1'b0;
    end else begin
      state_reg     <= state_next;
      burst_cnt_reg <= burst_cnt_next;
      turn_cnt_reg  <= turn_cnt_next;
      last_cpu_reg  <= last_cpu_next;
      dma_fair_reg  <= dma_fair_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    burst_cnt_next = burst_cnt_reg;
    turn_cnt_next  = turn_cnt_reg;
    last_cpu_next  = last_cpu_reg;
    dma_fair_next  = dma_fair_reg;
    released       = 1'b0;

    // Arbitration as seen from an idle bus. The DMA wins a tie only once,
    // right after a CPU tenure that it spent waiting.
    arb_state = ST_IDLE;
    if (cpu.req && dma.req) begin
      arb_state = (last_cpu_reg && dma_fair_reg) ? ST_DMA : ST_CPU;
    end else if (cpu.req) begin
      arb_state = ST_CPU;
    end else if (dma.req) begin
      arb_state = ST_DMA;
    end

    // Without turnaround the release edge hands over directly.
    release_state = (TURNAROUND_CYCLES == 0) ? arb_state : ST_TURN;

    // Count including the current cycle, so the limit takes effect on the
    // edge that completes the MAX_DMA_BURST-th contested cycle.
    burst_sat = burst_cnt_reg;
    if (cpu.req && (burst_cnt_reg != BURST_MAX)) begin
      burst_sat = burst_cnt_reg + 8'd1;
    end

    case (state_reg)
      ST_IDLE: begin
        state_next = arb_state;
      end
      ST_CPU: begin
        if (!cpu.req) begin
          state_next    = release_state;
          released      = 1'b1;
          last_cpu_next = 1'b1;
          dma_fair_next = dma.req;
        end
      end
      ST_DMA: begin
        burst_cnt_next = burst_sat;
        if (!dma.req || ((burst_sat == BURST_MAX) && (dma.ctl == CTL_IDLE))) begin
          state_next    = release_state;
          released      = 1'b1;
          last_cpu_next = 1'b0;
        end
      end
      ST_TURN: begin
        if (turn_cnt_reg == TURN_LAST) begin
          state_next = arb_state;
        end else begin
          turn_cnt_next = turn_cnt_reg + 2'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    // Entry bookkeeping; "released" covers a direct re-grant of the same
    // master when there is no turnaround.
    if ((state_next == ST_DMA) && ((state_reg != ST_DMA) || released)) begin
      burst_cnt_next = '0;
    end
    if ((state_next == ST_TURN) && (state_reg != ST_TURN)) begin
      turn_cnt_next = '0;
    end
    if (((state_next == ST_CPU) || (state_next == ST_DMA)) &&
        ((state_next != state_reg) || released)) begin
      dma_fair_next = 1'b0;
    end
  end

  assign cpu.gnt = (state_reg == ST_CPU);
  assign dma.gnt = (state_reg == ST_DMA);
  assign owner   = state_reg;

  bus_mux u_bus_mux (
    .owner        (state_reg),
    .cpu_address  (cpu.address),
    .cpu_data_out (cpu.data_out),
    .cpu_ctl      (cpu.ctl),
    .dma_address  (dma.address),
    .dma_data_out (dma.data_out),
    .dma_ctl      (dma.ctl),
    .address      (address),
    .ctl          (bus_ctl),
    .data         (data)
  );

  assign memNotRead  = bus_ctl[CTL_NRD];
  assign memNotWrite = bus_ctl[CTL_NWR];
  assign csh_n       = bus_ctl[CTL_CSH];
  assign csl_n       = bus_ctl[CTL_CSL];
  assign select_dev  = bus_ctl[CTL_SEL];

  // Read-back path: only the granted master is expected to use it.
  assign cpu.data_in = data;
  assign dma.data_in = data;

endmodule
